// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the two-requester ALU share arbiter:
// opcode encodings, operand/ID types and response buffer states.
package alu_pkg;

  localparam int OPCODE_LENGTH = 4;

  typedef logic [OPCODE_LENGTH-1:0] alu_op_t;
  typedef logic [0:0]               req_id_t;

  localparam alu_op_t ALU_AND = 4'b0000;
  localparam alu_op_t ALU_OR  = 4'b0001;
  localparam alu_op_t ALU_ADD = 4'b0010;
  localparam alu_op_t ALU_SUB = 4'b0011;
  localparam alu_op_t ALU_XOR = 4'b0100;
  localparam alu_op_t ALU_SLL = 4'b0101;
  localparam alu_op_t ALU_SRL = 4'b0110;
  localparam alu_op_t ALU_SRA = 4'b0111;
  localparam alu_op_t ALU_EQ  = 4'b1000;
  localparam alu_op_t ALU_NE  = 4'b1001;
  localparam alu_op_t ALU_LT  = 4'b1010;
  localparam alu_op_t ALU_GE  = 4'b1011;
  localparam alu_op_t ALU_JAL = 4'b1100;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: logic, arithmetic, shifts (amount from srcb[4:0]),
// compares returning 0/1, and a constant-1 opcode. Unknown opcodes give 0.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] srca,
  input  logic [DATA_WIDTH-1:0] srcb,
  input  alu_op_t               op,
  output logic [DATA_WIDTH-1:0] result
);

  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic [4:0] shamt;
  assign shamt = srcb[4:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_AND: result = srca & srcb;
      ALU_OR:  result = srca | srcb;
      ALU_ADD: result = srca + srcb;
      ALU_SUB: result = srca - srcb;
      ALU_XOR: result = srca ^ srcb;
      ALU_SLL: result = srca << shamt;
      ALU_SRL: result = srca >> shamt;
      ALU_SRA: result = $signed(srca) >>> shamt;
      ALU_EQ:  result = (srca == srcb) ? ONE : '0;
      ALU_NE:  result = (srca != srcb) ? ONE : '0;
      ALU_LT:  result = ($signed(srca) <  $signed(srcb)) ? ONE : '0;
      ALU_GE:  result = ($signed(srca) >= $signed(srcb)) ? ONE : '0;
      ALU_JAL: result = ONE;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two valid/ready requesters with a registered, ID-tagged
// single-entry response buffer. Define ALU_ARB_FIXED_PRIO_EN for fixed req0 priority.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_srca,
  input  logic [DATA_WIDTH-1:0] req0_srcb,
  input  logic [3:0]            req0_op,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_srca,
  input  logic [DATA_WIDTH-1:0] req1_srcb,
  input  logic [3:0]            req1_op,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_id,
  output logic [DATA_WIDTH-1:0] resp_data
);

  buf_state_t            buf_state;
  req_id_t               last_grant;
  req_id_t               grant_id;
  logic                  can_accept;
  logic                  grant_valid;
  logic [DATA_WIDTH-1:0] alu_srca;
  logic [DATA_WIDTH-1:0] alu_srcb;
  logic [DATA_WIDTH-1:0] alu_result;
  alu_op_t               alu_op;

  assign resp_valid  = (buf_state == BUF_FULL);
  assign can_accept  = ~resp_valid | resp_ready;
  assign grant_valid = ~reset & can_accept & (req0_valid | req1_valid);
  assign req0_ready  = grant_valid & (grant_id == 1'b0);
  assign req1_ready  = grant_valid & (grant_id == 1'b1);

  // On contention the requester that did not win last time goes next.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant_id = 1'b0;
`else
      grant_id = ~last_grant;
`endif
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  always_comb begin
    alu_srca = '0;
    alu_srcb = '0;
    alu_op   = ALU_AND;
    if (grant_valid) begin
      alu_srca = grant_id[0] ? req1_srca : req0_srca;
      alu_srcb = grant_id[0] ? req1_srcb : req0_srcb;
      alu_op   = grant_id[0] ? req1_op   : req0_op;
    end
  end

  alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .srca  (alu_srca),
    .srcb  (alu_srcb),
    .op    (alu_op),
    .result(alu_result)
  );

  // A fill takes precedence over a drain; a drain alone leaves data/id untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_state  <= BUF_EMPTY;
      resp_data  <= '0;
      resp_id    <= 1'b0;
      last_grant <= 1'b1;
    end else if (grant_valid) begin
      buf_state  <= BUF_FULL;
      resp_data  <= alu_result;
      resp_id    <= grant_id[0];
      last_grant <= grant_id;
    end else if (resp_ready) begin
      buf_state  <= BUF_EMPTY;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a reference ALU model queues expected
// responses on every accepted request; a negedge monitor pops and compares them.
module tb_alu_share_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_srca, req0_srcb;
  logic [3:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_srca, req1_srcb;
  logic [3:0]  req1_op;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_data;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic        hold0, hold1;
  logic [67:0] held0, held1;

  alu_share_arbiter #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_srca (req0_srca),
    .req0_srcb (req0_srcb),
    .req0_op   (req0_op),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_srca (req1_srca),
    .req1_srcb (req1_srcb),
    .req1_op   (req1_op),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id   (resp_id),
    .resp_data (resp_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    logic [4:0]  sh;
    logic        lt;
    logic [31:0] fill;
    sh   = b[4:0];
    lt   = (a[31] != b[31]) ? a[31] : (a < b);
    fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a - b;
      4'd4:    return a ^ b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      4'd7:    return (a >> sh) | fill;
      4'd8:    return {31'h0, a == b};
      4'd9:    return {31'h0, a != b};
      4'd10:   return {31'h0, lt};
      4'd11:   return {31'h0, ~lt};
      4'd12:   return 32'h1;
      default: return 32'h0;
    endcase
  endfunction

  // Response monitor: check the buffered result, then queue newly accepted ops.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      hold0 = 1'b0;
      hold1 = 1'b0;
    end else begin
      vectors++;
      if (resp_valid !== (sb.size() != 0)) begin
        miscompares++;
        $display("[TB] FAIL resp_valid: got %b, want %b", resp_valid, sb.size() != 0);
      end
      if (resp_valid === 1'b1 && sb.size() != 0) begin
        vectors++;
        if ({resp_id, resp_data} !== sb[0]) begin
          miscompares++;
          $display("[TB] FAIL resp: got id=%0d data=%h, want id=%0d data=%h",
                   resp_id, resp_data, sb[0].id, sb[0].data);
        end
        if (resp_ready) void'(sb.pop_front());
      end
      if (req0_valid && req0_ready) sb.push_back({1'b0, ref_alu(req0_srca, req0_srcb, req0_op)});
      if (req1_valid && req1_ready) sb.push_back({1'b1, ref_alu(req1_srca, req1_srcb, req1_op)});
      if (hold0 && req0_valid)
        assert ({req0_srca, req0_srcb, req0_op} == held0) else $error("[TB] req0 operands changed while stalled");
      if (hold1 && req1_valid)
        assert ({req1_srca, req1_srcb, req1_op} == held1) else $error("[TB] req1 operands changed while stalled");
      hold0 = req0_valid & ~req0_ready;
      hold1 = req1_valid & ~req1_ready;
      held0 = {req0_srca, req0_srcb, req0_op};
      held1 = {req1_srca, req1_srcb, req1_op};
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_reqs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_srca = 32'd1; req0_srcb = 32'd2; req0_op = 4'd2;
    req1_valid = 1'b1; req1_srca = 32'd3; req1_srcb = 32'd4; req1_op = 4'd2;
    @(negedge clk);
    vectors++;
    if ({resp_valid, resp_id, resp_data} !== 34'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got v=%b id=%b data=%h, want all zero", resp_valid, resp_id, resp_data);
    end
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_ready: got %b%b, want 00", req0_ready, req1_ready);
    end
    next_cycle();
    idle_reqs();
    next_cycle();
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_op();
    req0_valid = 1'b1; req0_srca = 32'd5; req0_srcb = 32'd7; req0_op = 4'd2;
    @(negedge clk);
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL single_ready: got %b%b, want 10", req0_ready, req1_ready);
    end
    next_cycle();
    idle_reqs();
    @(negedge clk);
    vectors++;
    if ({resp_valid, resp_id, resp_data} !== {1'b1, 1'b0, 32'd12}) begin
      miscompares++;
      $display("[TB] FAIL single_resp: got v=%b id=%0d data=%0d, want v=1 id=0 data=12",
               resp_valid, resp_id, resp_data);
    end
    next_cycle();
  endtask

  task automatic test_contention();
    logic exp_grant;
    do_reset();
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_srca = 32'd10;         req0_srcb = 32'd3; req0_op = 4'd3;
    req1_valid = 1'b1; req1_srca = 32'hFFFF_FFFF;  req1_srcb = 32'd1; req1_op = 4'd10;
    exp_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({req1_ready, req0_ready} !== (exp_grant ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("[TB] FAIL contention_grant[%0d]: got r0=%b r1=%b, want grant to req%0d",
                 i, req0_ready, req1_ready, exp_grant);
      end
      exp_grant = ~exp_grant;
      next_cycle();
    end
    idle_reqs();
    next_cycle();
  endtask

  task automatic test_fixed_prio();
    do_reset();
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_srca = 32'd10;         req0_srcb = 32'd3; req0_op = 4'd3;
    req1_valid = 1'b1; req1_srca = 32'hFFFF_FFFF;  req1_srcb = 32'd1; req1_op = 4'd10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({req1_ready, req0_ready} !== 2'b01) begin
        miscompares++;
        $display("[TB] FAIL fixed_prio[%0d]: got r0=%b r1=%b, want r0=1 r1=0", i, req0_ready, req1_ready);
      end
      next_cycle();
    end
    req0_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL fixed_prio_req1: got r0=%b r1=%b, want r0=0 r1=1", req0_ready, req1_ready);
    end
    next_cycle();
    idle_reqs();
    next_cycle();
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_srca = 32'h0000_F0F0; req0_srcb = 32'h0000_FF00; req0_op = 4'd0;
    next_cycle();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_srca = 32'h0000_1234; req1_srcb = 32'h0000_FFFF; req1_op = 4'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (req1_ready !== 1'b0 || resp_data !== 32'h0000_F000) begin
        miscompares++;
        $display("[TB] FAIL backpressure_hold[%0d]: got r1=%b data=%h, want r1=0 data=0000f000",
                 i, req1_ready, resp_data);
      end
      next_cycle();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (req1_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL backpressure_release: got r1=%b, want 1", req1_ready);
    end
    next_cycle();
    idle_reqs();
    @(negedge clk);
    vectors++;
    if ({resp_id, resp_data} !== {1'b1, 32'h0000_EDCB}) begin
      miscompares++;
      $display("[TB] FAIL backpressure_resp: got id=%0d data=%h, want id=1 data=0000edcb", resp_id, resp_data);
    end
    next_cycle();
  endtask

  task automatic test_signed_shift();
    req1_valid = 1'b1; req1_srca = 32'h8000_0000; req1_srcb = 32'd4; req1_op = 4'd7;
    next_cycle();
    idle_reqs();
    @(negedge clk);
    vectors++;
    if ({resp_valid, resp_id, resp_data} !== {1'b1, 1'b1, 32'hF800_0000}) begin
      miscompares++;
      $display("[TB] FAIL signed_shift: got v=%b id=%0d data=%h, want v=1 id=1 data=f8000000",
               resp_valid, resp_id, resp_data);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta [10];
    logic [31:0] tb [10];
    logic [3:0]  top[10];
    ta = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'd9, 32'd9,
           32'hFFFF_FFFE, 32'd3, 32'hDEAD_BEEF, 32'd0, 32'h1234_5678};
    tb = '{32'd1, 32'd31, 32'd31, 32'd9, 32'd8, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h0F0F_0F0F};
    top = '{4'd2, 4'd5, 4'd6, 4'd8, 4'd9, 4'd11, 4'd10, 4'd12, 4'd3, 4'd13};
    resp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req0_valid = 1'b1; req0_srca = ta[i]; req0_srcb = tb[i]; req0_op = top[i];
      @(negedge clk);
      vectors++;
      if (req0_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL back_to_back_ready[%0d]: got %b, want 1", i, req0_ready);
      end
      next_cycle();
    end
    idle_reqs();
    next_cycle();
  endtask

  task automatic test_reset_midop();
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_srca = 32'h0000_00F0; req0_srcb = 32'h0000_000F; req0_op = 4'd1;
    next_cycle();
    idle_reqs();
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({resp_valid, resp_data} !== 33'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_midop: got v=%b data=%h, want v=0 data=0", resp_valid, resp_data);
    end
    next_cycle();
    reset      = 1'b0;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_srca = 32'd1; req0_srcb = 32'd1; req0_op = 4'd2;
    req1_valid = 1'b1; req1_srca = 32'd2; req1_srcb = 32'd2; req1_op = 4'd2;
    @(negedge clk);
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL reset_midop_grant: got r0=%b r1=%b, want r0=1 r1=0", req0_ready, req1_ready);
    end
    next_cycle();
    idle_reqs();
    next_cycle();
  endtask

  task automatic test_random();
    logic stall0, stall1;
    stall0 = 1'b0;
    stall1 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!stall0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_srca  = $urandom();
        req0_srcb  = $urandom();
        req0_op    = 4'($urandom_range(0, 15));
      end
      if (!stall1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_srca  = $urandom();
        req1_srcb  = $urandom();
        req1_op    = 4'($urandom_range(0, 15));
      end
      resp_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      vectors++;
      if ((req0_ready & req1_ready) !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL random_one_hot[%0d]: got r0=%b r1=%b, want at most one", i, req0_ready, req1_ready);
      end
      stall0 = req0_valid & ~req0_ready;
      stall1 = req1_valid & ~req1_ready;
      next_cycle();
    end
    idle_reqs();
    resp_ready = 1'b1;
    repeat (3) next_cycle();
  endtask

  initial begin
    hold0 = 1'b0;
    hold1 = 1'b0;
    test_reset();
    test_single_op();
`ifdef ALU_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_contention();
`endif
    test_backpressure();
    test_signed_shift();
    test_back_to_back();
    test_reset_midop();
    test_random();
    @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending responses, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
